// File: rtl/cnt4_tc_2x_pkg.sv
// Width constant and increment helper for the 4-bit terminal-count counter.
package cnt4_tc_2x_pkg;

    // Fixed by the fan-in of the and4_2x decoder.
    localparam int CNT_W = 4;

    // Modulo-16 increment; the carry out of bit 3 is dropped on purpose.
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] q);
        return q + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/cnt4_tc_2x_cells.sv
// 2x-drive gate cells used by the counter's terminal-count decode.

// 4-input AND, 2x drive.
module and4_2x (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    input  logic i_d,
    output logic o_y
);
    assign o_y = i_a & i_b & i_c & i_d;
endmodule

// 2-input NAND, 2x drive.
module nand_2x (
    input  logic i_a,
    input  logic i_b,
    output logic o_y
);
    assign o_y = ~(i_a & i_b);
endmodule

// File: rtl/cnt4_tc_2x.sv
// 4-bit up-counter with parallel load, combinational terminal count (TC),
// registered one-cycle carry (CO) and a sticky wrap flag (WRAP).
module cnt4_tc_2x
    import cnt4_tc_2x_pkg::*;
#(
    parameter logic [CNT_W-1:0] RST_VAL = 4'h0
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             EN,
    input  logic             LD,
    input  logic [CNT_W-1:0] D,
    input  logic             CLR,
    output logic [CNT_W-1:0] Q,
    output logic             TC,
    output logic             CO,
    output logic             WRAP
);

    logic [CNT_W-1:0] r_q;
    logic             r_co;
    logic             r_wrap;
    logic             w_all1;
    logic             w_tc_n;
    logic             w_tc;
    logic             w_wrap;

    // All-ones decode of the counter state.
    and4_2x u_dec (
        .i_a (r_q[3]),
        .i_b (r_q[2]),
        .i_c (r_q[1]),
        .i_d (r_q[0]),
        .o_y (w_all1)
    );

    // EN qualification: NAND followed by an inverter forms the 2-input AND.
    nand_2x u_en_qual (
        .i_a (w_all1),
        .i_b (EN),
        .o_y (w_tc_n)
    );
    assign w_tc = ~w_tc_n;

    // A wrap is a count step taken from 4'hF; a load in the same cycle suppresses it.
    assign w_wrap = w_tc & ~LD;

    // Counter, carry and sticky-wrap state; reset > load > count > hold.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_q    <= RST_VAL;
            r_co   <= 1'b0;
            r_wrap <= 1'b0;
        end else begin
            if (LD) begin
                r_q <= D;
            end else if (EN) begin
                r_q <= cnt_inc(r_q);
            end
            r_co <= w_wrap;
            // Setting on a wrap beats a simultaneous clear.
            if (w_wrap) begin
                r_wrap <= 1'b1;
            end else if (CLR) begin
                r_wrap <= 1'b0;
            end
        end
    end

    assign Q    = r_q;
    assign TC   = w_tc;
    assign CO   = r_co;
    assign WRAP = r_wrap;

endmodule
